serial_subtractor: RTL and testbench

- Bit-serial, multi-cycle subtractor: computes diff = a - b - bin, one bit per clock, LSB first, through a single registered full-subtractor cell and a borrow flip-flop.
- Inverse-direction companion to the combinational ripple adder.
- Used where area matters more than latency: one subtractor cell replaces WIDTH cells.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 tb/tb_serial_subtractor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, diff = a - b - bin, one bit per clock LSB first
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             ak;
    logic             bk;
    logic             d;
    logic             br_nxt;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_nxt;
    logic             accept;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs and the result shifted in from the top
    always_comb begin
        ak       = a_sr[0];
        bk       = b_sr[0];
        d        = ak ^ bk ^ br;
        br_nxt   = (~ak & bk) | (~(ak ^ bk) & br);
        res_cat  = {d, res_sr};
        res_nxt  = res_cat[WIDTH:1];
        accept   = in_valid & in_ready;
        last_bit = (cnt == LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, serial datapath and result registers (results only move at RUN->DONE)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        res_sr <= '0;
                        br     <= bin;
                        cnt    <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    br     <= br_nxt;
                    if (last_bit) begin
                        diff <= res_nxt;
                        bout <= br_nxt;
                        ovf  <= (a_msb != b_msb) & (res_nxt[WIDTH-1] != a_msb);
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         bin       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int d;
        int bo;
        int ov;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   errors     = 0;
    int   checks     = 0;
    int   ready_mode = 0;
    int   last_hs    = -1;
    int   done_cnt   = 0;
    int   sent       = 0;
    bit   seen       = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    function automatic exp_t model(input int ta, input int tb_, input int tbi, input int acc);
        exp_t e;
        int   sa;
        int   sbv;
        int   sr;
        int   half;
        half  = 1 << (W - 1);
        e.d   = (ta - tb_ - tbi) & ((1 << W) - 1);
        e.bo  = (ta < tb_ + tbi) ? 1 : 0;
        sa    = (ta >= half) ? ta - (1 << W) : ta;
        sbv   = (tb_ >= half) ? tb_ - (1 << W) : tb_;
        sr    = sa - sbv - tbi;
        e.ov  = (sr < -half || sr > half - 1) ? 1 : 0;
        e.acc = acc;
        return e;
    endfunction

    // Present operands from a falling edge, wait for acceptance, push the expected result
    task automatic send(input int ta, input int tb_, input int tbi, output int acc);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        a        = ta[W-1:0];
        b        = tb_[W-1:0];
        bin      = tbi[0];
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0d expected 1", in_ready);
            acc      = -1;
            in_valid = 1'b0;
            return;
        end
        acc = edge_cnt + 1;
        sb.push_back(model(ta, tb_, tbi, acc));
        sent++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    // Monitor: drives out_ready and checks every presented result against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (!rst_n) begin
                seen = 0;
            end else if (out_valid) begin
                chk("in_ready_while_valid", in_ready, 0);
                if (sb.size() == 0) begin
                    chk("spurious_result", sb.size(), 1);
                end else begin
                    if (!seen) begin
                        seen = 1;
                        chk("latency", edge_cnt, sb[0].acc + W);
                    end
                    chk("diff", diff, sb[0].d);
                    chk("bout", bout, sb[0].bo);
                    chk("ovf", ovf, sb[0].ov);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen    = 0;
                        last_hs = edge_cnt + 1;
                        done_cnt++;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int acc;
        int guard;
        int pend;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(9, 3, 0, acc);
        for (int i = 0; i < 5; i++) begin
            chk("in_ready_busy", in_ready, 0);
            @(negedge clk);
        end
        wait_drain();

        send(3, 5, 0, acc);
        send(0, 0, 1, acc);
        send(7, 8, 0, acc);
        send(15, 15, 0, acc);
        wait_drain();

        // Backpressure with in_valid held and operands wandering
        #1 ready_mode = 2;
        @(negedge clk);
        send(12, 4, 0, acc);
        guard = 0;
        in_valid = 1'b1;
        while (!out_valid && guard < 50) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            guard++;
        end
        chk("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_diff_hold", diff, 8);
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
        end
        #1 ready_mode = 0;
        send(5, 2, 0, acc);
        chk("accept_after_release", acc, last_hs + 1);
        wait_drain();

        // Reset in the middle of a run
        send(10, 1, 0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_in_ready", in_ready, 1);
        pend = sb.size();
        sb.delete();
        sent = sent - pend;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(10, 1, 0, acc);
        wait_drain();

        // Random stream with random backpressure
        #1 ready_mode = 1;
        @(negedge clk);
        for (int n = 0; n < 100; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)), acc);
        end
        #1 ready_mode = 0;
        wait_drain();
        chk("result_count", done_cnt, sent);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
